frame_downsampler: RTL and testbench

Consumes the RGB565 pixel stream from the camera capture stage (pixel_data / pixel_valid / frame_done) and produces the 28x28 8-bit grayscale image the digit classifier reads. Each pixel is converted to grayscale, a fixed 224x224 window is cropped from the 320x240 frame, and each 8x8 block in that window is averaged into one output pixel. Output pixels are written to the classifier's image buffer through a simple write port. A one-cycle pulse marks each completed image.

---
 rtl/frame_downsampler.sv | 149 ++++++++++++++
 tb/tb_frame_downsampler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/frame_downsampler.sv
// rtl/frame_downsampler.sv - RGB565 camera stream to 28x28 grayscale block-averaged image
//
// Converts each accepted pixel to 8-bit gray. It crops a fixed 224x224 window at (X0, Y0)
// and averages each 8x8 block of that window into one output pixel. Each output pixel is
// written to the classifier image buffer.
//
// Ports:
//   p_clock      pixel clock (only clock)
//   reset        asynchronous active-high reset
//   pixel_data   RGB565 pixel, R[15:11] G[10:5] B[4:0]
//   pixel_valid  pixel_data valid this cycle
//   frame_done   one-cycle pulse at frame boundary
//   out_addr     image buffer address, by*28+bx
//   out_data     averaged (optionally inverted) gray value
//   out_we       one-cycle write strobe per output pixel
//   frame_ready  one-cycle pulse together with the write to address 783
module frame_downsampler #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int X0     = 48,
    parameter int Y0     = 8,
    parameter bit INVERT = 1'b1
) (
    input  logic        p_clock,
    input  logic        reset,
    input  logic [15:0] pixel_data,
    input  logic        pixel_valid,
    input  logic        frame_done,
    output logic [9:0]  out_addr,
    output logic [7:0]  out_data,
    output logic        out_we,
    output logic        frame_ready
);

    localparam int WIN  = 224;
    localparam int BLKS = 28;

    localparam logic [8:0] X_LO   = 9'(X0);
    localparam logic [8:0] X_HI   = 9'(X0 + WIN);
    localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
    localparam logic [7:0] Y_LO   = 8'(Y0);
    localparam logic [7:0] Y_HI   = 8'(Y0 + WIN);
    localparam logic [7:0] Y_END  = 8'(IMG_H);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [13:0] acc_q [BLKS];
    logic [13:0] acc_d [BLKS];
    logic [9:0]  out_addr_q, out_addr_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_we_q, out_we_d;
    logic        frame_ready_q, frame_ready_d;

    logic [7:0]  r8, g8, b8, gray;
    logic [9:0]  sum10;
    logic [7:0]  dx, dy;
    logic [4:0]  bx, by;
    logic [13:0] blk_sum;
    logic        in_win, blk_last, accept;

    always_comb begin
        // Channel expansion replicates the MSBs so full-scale maps to 255.
        r8    = {pixel_data[15:11], pixel_data[15:13]};
        g8    = {pixel_data[10:5], pixel_data[10:9]};
        b8    = {pixel_data[4:0], pixel_data[4:2]};
        sum10 = 10'(r8) + {1'b0, g8, 1'b0} + 10'(b8);
        gray  = 8'(sum10 >> 2);

        in_win   = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
        dx       = 8'(x_q - X_LO);
        dy       = y_q - Y_LO;
        bx       = dx[7:3];
        by       = dy[7:3];
        blk_sum  = acc_q[bx] + 14'(gray);
        blk_last = (dx[2:0] == 3'd7) && (dy[2:0] == 3'd7);
        // A frame_done in the same cycle discards the pixel.
        accept   = (state_q == ACTIVE) && pixel_valid && !frame_done && (y_q < Y_END);

        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        acc_d         = acc_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        out_we_d      = 1'b0;
        frame_ready_d = 1'b0;

        if (frame_done) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            for (int i = 0; i < BLKS; i++) begin
                acc_d[i] = '0;
            end
        end else if (accept) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + 8'd1;
            end else begin
                x_d = x_q + 9'd1;
            end
            if (in_win) begin
                if (blk_last) begin
                    // Accumulator is freed here for the next block row in this column.
                    acc_d[bx]     = '0;
                    out_we_d      = 1'b1;
                    out_addr_d    = 10'(by) * 10'd28 + 10'(bx);
                    out_data_d    = INVERT ? ~blk_sum[13:6] : blk_sum[13:6];
                    frame_ready_d = (bx == 5'd27) && (by == 5'd27);
                end else begin
                    acc_d[bx] = blk_sum;
                end
            end
        end
    end

    always_ff @(posedge p_clock or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            x_q           <= '0;
            y_q           <= '0;
            for (int i = 0; i < BLKS; i++) begin
                acc_q[i] <= '0;
            end
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_we_q      <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            acc_q         <= acc_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_we_q      <= out_we_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign out_we      = out_we_q;
    assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_frame_downsampler.sv
// tb/tb_frame_downsampler.sv - directed self-checking bench for frame_downsampler
module tb_frame_downsampler;

    localparam int TW  = 232;
    localparam int TH  = 228;
    localparam int TX0 = 4;
    localparam int TY0 = 2;
    localparam int T00 = (TY0 + 7) * TW + TX0 + 7;

    logic        p_clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_done = 1'b0;

    logic [9:0]  out_addr, inv_addr;
    logic [7:0]  out_data, inv_data;
    logic        out_we, inv_we;
    logic        frame_ready, inv_ready;

    frame_downsampler #(.IMG_W(TW), .IMG_H(TH), .X0(TX0), .Y0(TY0), .INVERT(1'b0)) dut (
        .p_clock(p_clock), .reset(reset), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .out_addr(out_addr), .out_data(out_data), .out_we(out_we), .frame_ready(frame_ready)
    );

    frame_downsampler #(.IMG_W(TW), .IMG_H(TH), .X0(TX0), .Y0(TY0), .INVERT(1'b1)) dut_inv (
        .p_clock(p_clock), .reset(reset), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .out_addr(inv_addr), .out_data(inv_data), .out_we(inv_we), .frame_ready(inv_ready)
    );

    always #5 p_clock = ~p_clock;

    int         n_vec = 0;
    int         n_bad = 0;
    int         wr_cnt = 0;
    int         fr_cnt = 0;
    int         wr_base;
    int         fr_base;
    logic [9:0] exp_addr = '0;
    bit         chk_main = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_val(input logic [9:0] a);
        case (a)
            10'd0:   return 8'd255;
            10'd1:   return 8'd127;
            10'd783: return 8'd131;
            default: return 8'd0;
        endcase
    endfunction

    // Main frame image: white outside the crop, hot block 0, half-white block 1, 8410 in block 783.
    function automatic logic [15:0] pat(input int x, input int y);
        int dx, dy;
        if (x < TX0 || x >= TX0 + 224 || y < TY0 || y >= TY0 + 224) return 16'hFFFF;
        dx = x - TX0;
        dy = y - TY0;
        if (dx < 8 && dy < 8) return 16'hFFFF;
        if (dx >= 8 && dx < 16 && dy < 4) return 16'hFFFF;
        if (dx >= 216 && dy >= 216) return 16'h8410;
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge p_clock);
        #1;
        if (out_we === 1'b1) begin
            if (chk_main) begin
                chk("wr_addr", 32'(out_addr), 32'(exp_addr));
                chk("wr_data", 32'(out_data), 32'(exp_val(exp_addr)));
                chk("wr_inv_we", 32'(inv_we), 32'd1);
                chk("wr_inv_data", 32'(inv_data), 32'(8'hFF - exp_val(exp_addr)));
                chk("ready_at_wr", 32'(frame_ready), 32'(exp_addr == 10'd783));
            end
            wr_cnt++;
            exp_addr++;
        end
        if (frame_ready === 1'b1) fr_cnt++;
    endtask

    task automatic pix(input logic [15:0] d);
        pixel_data  = d;
        pixel_valid = 1'b1;
        frame_done  = 1'b0;
        tick();
    endtask

    task automatic fd(input bit with_pix);
        pixel_data  = 16'hFFFF;
        pixel_valid = with_pix;
        frame_done  = 1'b1;
        tick();
        frame_done  = 1'b0;
        pixel_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_we", 32'(out_we), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ready", 32'(frame_ready), 32'd0);
        reset = 1'b0;

        // Pixels before the first frame_done are ignored
        for (int i = 0; i < 10 * TW; i++) pix(16'hFFFF);
        pixel_valid = 1'b0;
        chk("presync_writes", 32'(wr_cnt), 32'd0);

        // Aborted frame: 20 white rows, then a new frame_done
        fd(1'b0);
        wr_base = wr_cnt;
        fr_base = fr_cnt;
        for (int i = 0; i < 20 * TW; i++) pix(16'hFFFF);
        pixel_valid = 1'b0;
        chk("abort_writes", 32'(wr_cnt - wr_base), 32'd56);
        chk("abort_ready", 32'(fr_cnt - fr_base), 32'd0);

        // Full frame with pattern
        fd(1'b0);
        wr_base  = wr_cnt;
        fr_base  = fr_cnt;
        exp_addr = '0;
        chk_main = 1'b1;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                pix(pat(x, y));
                if (x == TX0 + 7 && y == TY0 + 7) begin
                    chk("addr0_time_we", 32'(out_we), 32'd1);
                    chk("addr0_time_addr", 32'(out_addr), 32'd0);
                end
            end
        end
        pixel_valid = 1'b0;
        chk_main = 1'b0;
        chk("main_writes", 32'(wr_cnt - wr_base), 32'd784);
        chk("main_ready", 32'(fr_cnt - fr_base), 32'd1);
        chk("inv_ready_seen", 32'(inv_ready), 32'd0);

        // Reset while a write is on the outputs
        fd(1'b0);
        for (int i = 0; i <= T00; i++) pix(16'hFFFF);
        pixel_valid = 1'b0;
        chk("pre_rst_we", 32'(out_we), 32'd1);
        chk("pre_rst_data", 32'(out_data), 32'd255);
        reset = 1'b1;
        #1;
        chk("async_rst_we", 32'(out_we), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_inv_we", 32'(inv_we), 32'd0);
        tick();
        reset = 1'b0;

        // After reset no writes until frame_done
        wr_base = wr_cnt;
        for (int i = 0; i < 10 * TW; i++) pix(16'hFFFF);
        pixel_valid = 1'b0;
        chk("post_rst_writes", 32'(wr_cnt - wr_base), 32'd0);

        // frame_done together with pixel_valid: pixel is discarded
        fd(1'b1);
        for (int i = 0; i <= T00; i++) begin
            pix(16'hFFFF);
            if (i == T00 - 1) chk("coincide_early_we", 32'(out_we), 32'd0);
            if (i == T00) begin
                chk("coincide_we", 32'(out_we), 32'd1);
                chk("coincide_addr", 32'(out_addr), 32'd0);
                chk("coincide_data", 32'(out_data), 32'd255);
                chk("coincide_inv_data", 32'(inv_data), 32'd0);
            end
        end
        pixel_valid = 1'b0;
        tick();
        chk("we_single_cycle", 32'(out_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
